pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Generates the enable and flush strobes for the PC, IF/ID and ID/EX registers.
//  Handles three events: load-use stalls, taken branch/jump flushes, and the syscall-10 halt with pipeline drain.
//  Sits beside the pipeline registers; consumes only ID/EX-side decode and control signals.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (>=1; >1 for slow RAM)
//  DRAIN_CYCLES       2   cycles after halt for EX/MEM and MEM/WB to retire (>=1)
//  CNT_W              32  width of performance counters
// PORTS
//  clk             in   1      system clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  MemRead_id_ex   in   1      instruction in EX is a load
//  rt_id_ex        in   5      load destination register in EX
//  rs_id           in   5      source register rs of instruction in ID
//  rt_id           in   5      source register rt of instruction in ID
//  uses_rs_id      in   1      ID instruction reads rs
//  uses_rt_id      in   1      ID instruction reads rt
//  pc_bj_ex        in   1      branch taken / jump resolved in EX
//  halt_ex         in   1      syscall with $v0==10 in EX
//  pc_en           out  1      PC register load enable
//  if_id_en        out  1      IF/ID load enable
//  if_id_flush     out  1      IF/ID clear to NOP (dominates if_id_en)
//  id_ex_flush     out  1      ID/EX clear to bubble (all control bits 0)
//  halted          out  1      pipeline fully drained after halt
//  state_o         out  3      current FSM state (debug)
// BEHAVIOUR
//  States: INIT=0, RUN=1, STALL=2, DRAIN=3, HALT=4. Register state only; strobes are combinational from state+inputs.
//  Reset (rst_n=0, async): state=INIT, drain/stall counters=0, perf counters=0.
//  Reset strobe values: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, halted=0.
//  INIT: same strobes as reset. Lasts exactly one cycle after rst_n rises, then RUN.
//  RUN, no event: pc_en=1, if_id_en=1, flushes=0.
//  hazard = MemRead_id_ex & rt_id_ex!=0 & ((uses_rs_id & rs_id==rt_id_ex) | (uses_rt_id & rt_id==rt_id_ex)).
//  RUN+hazard: pc_en=0, if_id_en=0, id_ex_flush=1 (first bubble, same cycle).
//   If LOAD_STALL_CYCLES>1: go to STALL with cnt=LOAD_STALL_CYCLES-2.
//  STALL: same strobes as the hazard cycle. cnt decrements; at cnt==0 return to RUN.
//   Hazard is not re-evaluated while in STALL: EX holds a bubble.
//  RUN+pc_bj_ex: pc_en=1 (loads target), if_id_flush=1, id_ex_flush=1. Kills the 2 wrong-path instructions; stays in RUN.
//  RUN+halt_ex: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1. Go to DRAIN with cnt=DRAIN_CYCLES-1.
//  DRAIN: strobes as in the halt cycle. cnt decrements; at cnt==0 go to HALT.
//  HALT: strobes as in DRAIN, halted=1. Only rst_n leaves HALT (syscall 10 is program exit).
//  Priority in the same cycle: halt_ex > pc_bj_ex > hazard.
//   Branch beats hazard because the ID instruction is wrong-path; no stall is taken.
//  pc_bj_ex/halt_ex are ignored outside RUN (EX holds a bubble in STALL/DRAIN).
//  rst_n asserted mid-STALL/DRAIN: immediate return to INIT and counters cleared; no partial bubble.
// CONFIGURATION
//  PERF_CNT_EN defined: adds outputs cycle_cnt, stall_cnt, flush_cnt [CNT_W-1:0].
//   cycle_cnt increments each cycle in RUN/STALL.
//   stall_cnt increments each bubble cycle (hazard cycle + STALL).
//   flush_cnt increments each pc_bj_ex flush cycle.
//   All counters saturate at all-ones, freeze in DRAIN/HALT, and clear on reset.
//  PERF_CNT_EN undefined: those ports and counters are absent; all other behaviour identical.
// TESTING
//  Reset release: rst_n 0->1 -> one INIT cycle (pc_en=0, flushes=1), then RUN with pc_en=1.
//  lw $t0 in EX (rt_id_ex=8, MemRead=1), ID add uses rs=8 -> that cycle pc_en=0, id_ex_flush=1; next cycle RUN.
//   With LOAD_STALL_CYCLES=3: 3 consecutive bubble cycles, then RUN.
//  Hazard on $zero (rt_id_ex=0, rs_id=0) -> no stall, pc_en=1.
//  pc_bj_ex=1 together with hazard -> pc_en=1, if_id_flush=1, id_ex_flush=1, no STALL entry.
//  halt_ex=1 -> DRAIN for 2 cycles, then halted=1 on cycle 3 and held.
//   Further pc_bj_ex/halt_ex pulses ignored; rst_n pulse returns to INIT.
//  PERF_CNT_EN: 10 RUN cycles with 2 load stalls and 1 flush -> cycle_cnt=10, stall_cnt=2, flush_cnt=1.
//   Preset cycle_cnt near max -> saturates at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the 5-stage MIPS datapath (master) and pipeline_ctrl (slave).
// The cycle/stall/flush counter signals exist only when PERF_CNT_EN is defined.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic       MemRead_id_ex;
    logic [4:0] rt_id_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       uses_rs_id;
    logic       uses_rt_id;
    logic       pc_bj_ex;
    logic       halt_ex;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       halted;
    logic [2:0] state_o;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output MemRead_id_ex, rt_id_ex, rs_id, rt_id, uses_rs_id, uses_rt_id, pc_bj_ex, halt_ex,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, halted, state_o,
        input  cycle_cnt, stall_cnt, flush_cnt
    );
    modport slave (
        input  MemRead_id_ex, rt_id_ex, rs_id, rt_id, uses_rs_id, uses_rt_id, pc_bj_ex, halt_ex,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, halted, state_o,
        output cycle_cnt, stall_cnt, flush_cnt
    );
`else
    modport master (
        output MemRead_id_ex, rt_id_ex, rs_id, rt_id, uses_rs_id, uses_rt_id, pc_bj_ex, halt_ex,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, halted, state_o
    );
    modport slave (
        input  MemRead_id_ex, rt_id_ex, rs_id, rt_id, uses_rs_id, uses_rt_id, pc_bj_ex, halt_ex,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, halted, state_o
    );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: load-use stalls, branch flushes, halt drain.
// Define PERF_CNT_EN to add saturating cycle/stall/flush performance counters.
module pipeline_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 2,
    parameter int CNT_W             = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_ctrl_if.slave    bus
);
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    // One shared down-counter serves both STALL and DRAIN; size it for the larger reload.
    localparam int STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
    localparam int DRAIN_RELOAD = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0;
    localparam int CNT_MAX      = (STALL_RELOAD > DRAIN_RELOAD) ? STALL_RELOAD : DRAIN_RELOAD;
    localparam int CW           = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hazard;
    logic          pcEn, ifIdEn, ifIdFlush, idExFlush, haltedOut;

    assign hazard = bus.MemRead_id_ex && (bus.rt_id_ex != 5'd0) &&
                    ((bus.uses_rs_id && (bus.rs_id == bus.rt_id_ex)) ||
                     (bus.uses_rt_id && (bus.rt_id == bus.rt_id_ex)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pcEn      = 1'b0;
        ifIdEn    = 1'b0;
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
        haltedOut = 1'b0;
        case (state_q)
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                // halt beats branch beats hazard: a branch makes the ID instruction wrong-path
                if (bus.halt_ex) begin
                    state_d = S_DRAIN;
                    cnt_d   = CW'(DRAIN_RELOAD);
                end else if (bus.pc_bj_ex) begin
                    pcEn   = 1'b1;
                    ifIdEn = 1'b1;
                end else if (hazard) begin
                    ifIdFlush = 1'b0;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = S_STALL;
                        cnt_d   = CW'(STALL_RELOAD);
                    end
                end else begin
                    pcEn      = 1'b1;
                    ifIdEn    = 1'b1;
                    ifIdFlush = 1'b0;
                    idExFlush = 1'b0;
                end
            end
            S_STALL: begin
                ifIdFlush = 1'b0;
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_HALT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_HALT:  haltedOut = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_en       = pcEn;
    assign bus.if_id_en    = ifIdEn;
    assign bus.if_id_flush = ifIdFlush;
    assign bus.id_ex_flush = idExFlush;
    assign bus.halted      = haltedOut;
    assign bus.state_o     = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycleCnt_q, stallCnt_q, flushCnt_q;
    logic             active, stallEvt, flushEvt;

    // Events only occur in RUN/STALL, so the counters freeze by themselves in DRAIN/HALT.
    assign active   = (state_q == S_RUN) || (state_q == S_STALL);
    assign flushEvt = (state_q == S_RUN) && !bus.halt_ex && bus.pc_bj_ex;
    assign stallEvt = (state_q == S_STALL) ||
                      ((state_q == S_RUN) && !bus.halt_ex && !bus.pc_bj_ex && hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt_q <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (active && (cycleCnt_q != '1))   cycleCnt_q <= cycleCnt_q + CNT_W'(1);
            if (stallEvt && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + CNT_W'(1);
            if (flushEvt && (flushCnt_q != '1)) flushCnt_q <= flushCnt_q + CNT_W'(1);
        end
    end

    assign bus.cycle_cnt = cycleCnt_q;
    assign bus.stall_cnt = stallCnt_q;
    assign bus.flush_cnt = flushCnt_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: RUN-state vector table plus stall, drain/halt, reset and counter sequences.
// Two instances share stimulus: default parameters and LOAD_STALL_CYCLES=3.
module tb_pipeline_ctrl;
    localparam int TB_CNT_W = 4;
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(TB_CNT_W)) busA ();
    pipeline_ctrl_if #(.CNT_W(TB_CNT_W)) busB ();

    pipeline_ctrl #(.LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(2), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(busA)
    );
    pipeline_ctrl #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(2), .CNT_W(TB_CNT_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(busB)
    );

    typedef struct {
        logic       memRead;
        logic [4:0] rtEx, rsId, rtId;
        logic       usesRs, usesRt, bj, halt;
        logic       pcEn, ifIdEn, ifIdEnCare, ifIdFlush, idExFlush;
        logic [2:0] nextState;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic memRead, input logic [4:0] rtEx, input logic [4:0] rsId,
                                 input logic [4:0] rtId, input logic usesRs, input logic usesRt,
                                 input logic bj, input logic halt);
        busA.MemRead_id_ex = memRead; busB.MemRead_id_ex = memRead;
        busA.rt_id_ex = rtEx;         busB.rt_id_ex = rtEx;
        busA.rs_id = rsId;            busB.rs_id = rsId;
        busA.rt_id = rtId;            busB.rt_id = rtId;
        busA.uses_rs_id = usesRs;     busB.uses_rs_id = usesRs;
        busA.uses_rt_id = usesRt;     busB.uses_rt_id = usesRt;
        busA.pc_bj_ex = bj;           busB.pc_bj_ex = bj;
        busA.halt_ex = halt;          busB.halt_ex = halt;
    endtask

    task automatic clearStimulus();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Holds reset for two cycles, releases just after an edge, checks the INIT cycle, ends just after entering RUN.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        clearStimulus();
        @(negedge clk);
        checkOutput({tag, "_rst_state"}, 32'(busA.state_o), 32'(S_INIT));
        checkOutput({tag, "_rst_strobes"},
                    {28'd0, busA.pc_en, busA.if_id_en, busA.if_id_flush, busA.id_ex_flush}, 32'b0011);
        checkOutput({tag, "_rst_halted"}, 32'(busA.halted), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_init_state"}, 32'(busA.state_o), 32'(S_INIT));
        checkOutput({tag, "_init_pc_en"}, 32'(busA.pc_en), 32'd0);
        checkOutput({tag, "_init_flushes"}, {30'd0, busA.if_id_flush, busA.id_ex_flush}, 32'b11);
        @(posedge clk);
        #1;
        checkOutput({tag, "_run_state"}, 32'(busA.state_o), 32'(S_RUN));
        checkOutput({tag, "_run_pc_en"}, 32'(busA.pc_en), 32'd1);
        checkOutput({tag, "_run3_state"}, 32'(busB.state_o), 32'(S_RUN));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          mem rtEx   rsId   rtId   uRs   uRt   bj    halt  pc    en    care  iff   ief   next
        vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN};
        vecs[1] = '{1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_RUN};
        vecs[2] = '{1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_RUN};
        vecs[3] = '{1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN};
        vecs[4] = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN};
        vecs[5] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN};
        vecs[6] = '{1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN};
        vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_RUN};
        vecs[8] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_RUN};
        vecs[9] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_DRAIN};

        doReset("r0");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].memRead, vecs[i].rtEx, vecs[i].rsId, vecs[i].rtId,
                          vecs[i].usesRs, vecs[i].usesRt, vecs[i].bj, vecs[i].halt);
            @(negedge clk);
            checkOutput($sformatf("v%0d_pc_en", i), 32'(busA.pc_en), 32'(vecs[i].pcEn));
            if (vecs[i].ifIdEnCare)
                checkOutput($sformatf("v%0d_if_id_en", i), 32'(busA.if_id_en), 32'(vecs[i].ifIdEn));
            checkOutput($sformatf("v%0d_if_id_flush", i), 32'(busA.if_id_flush), 32'(vecs[i].ifIdFlush));
            checkOutput($sformatf("v%0d_id_ex_flush", i), 32'(busA.id_ex_flush), 32'(vecs[i].idExFlush));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_next_state", i), 32'(busA.state_o), 32'(vecs[i].nextState));
        end

        // Drain: two DRAIN cycles after the halt cycle, then HALT held against further events
        clearStimulus();
        @(negedge clk);
        checkOutput("drain1_strobes",
                    {27'd0, busA.pc_en, busA.if_id_en, busA.if_id_flush, busA.id_ex_flush, busA.halted}, 32'b00110);
        @(posedge clk);
        #1 checkOutput("drain2_state", 32'(busA.state_o), 32'(S_DRAIN));
        @(negedge clk);
        checkOutput("drain2_halted", 32'(busA.halted), 32'd0);
        @(posedge clk);
        #1 checkOutput("halt_state", 32'(busA.state_o), 32'(S_HALT));
        @(negedge clk);
        checkOutput("halt_strobes",
                    {27'd0, busA.pc_en, busA.if_id_en, busA.if_id_flush, busA.id_ex_flush, busA.halted}, 32'b00111);
        applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 clearStimulus();
        checkOutput("halt_ignores_events", 32'(busA.state_o), 32'(S_HALT));
        @(negedge clk);
        checkOutput("halt_held", 32'(busA.halted), 32'd1);
        rst_n = 1'b0;
        #1 checkOutput("halt_async_rst", 32'(busA.state_o), 32'(S_INIT));
        checkOutput("halt_async_rst_halted", 32'(busA.halted), 32'd0);

        // Three-bubble load stall on dut3, single bubble on dut
        doReset("r1");
        applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s3_b1", {30'd0, busB.pc_en, busB.id_ex_flush}, 32'b01);
        @(posedge clk);
        #1 clearStimulus();
        checkOutput("s3_enter_stall", 32'(busB.state_o), 32'(S_STALL));
        checkOutput("s1_no_stall", 32'(busA.state_o), 32'(S_RUN));
        @(negedge clk);
        checkOutput("s3_b2", {29'd0, busB.pc_en, busB.if_id_en, busB.id_ex_flush}, 32'b001);
        checkOutput("s1_resumed", 32'(busA.pc_en), 32'd1);
        @(posedge clk);
        #1 checkOutput("s3_still_stall", 32'(busB.state_o), 32'(S_STALL));
        @(negedge clk);
        checkOutput("s3_b3", {30'd0, busB.pc_en, busB.id_ex_flush}, 32'b01);
        @(posedge clk);
        #1 checkOutput("s3_back_run", 32'(busB.state_o), 32'(S_RUN));
        @(negedge clk);
        checkOutput("s3_run_strobes", {30'd0, busB.pc_en, busB.id_ex_flush}, 32'b10);

        // Reset during STALL: immediate INIT, and no leftover bubble after release
        @(posedge clk);
        #1 applyStimulus(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 clearStimulus();
        checkOutput("s3_stall_again", 32'(busB.state_o), 32'(S_STALL));
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkOutput("s3_async_rst", 32'(busB.state_o), 32'(S_INIT));
        checkOutput("s3_async_rst_pc_en", 32'(busB.pc_en), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("s3_after_rst_run", 32'(busB.state_o), 32'(S_RUN));
        @(negedge clk);
        checkOutput("s3_after_rst_pc_en", 32'(busB.pc_en), 32'd1);

`ifdef PERF_CNT_EN
        // Ten counted cycles: loads stall at cycles 1 and 4, branch flush at cycle 6
        doReset("r2");
        for (int i = 0; i < 10; i++) begin
            if (i == 1 || i == 4) applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (i == 6)      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            else                  clearStimulus();
            @(posedge clk);
            #1;
        end
        clearStimulus();
        checkOutput("perf_cycle", 32'(busA.cycle_cnt), 32'd10);
        checkOutput("perf_stall", 32'(busA.stall_cnt), 32'd2);
        checkOutput("perf_flush", 32'(busA.flush_cnt), 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 clearStimulus();
        repeat (4) @(posedge clk);
        #1 checkOutput("perf_frozen_cycle", 32'(busA.cycle_cnt), 32'd11);
        checkOutput("perf_frozen_stall", 32'(busA.stall_cnt), 32'd2);
        doReset("r3");
        checkOutput("perf_cleared", 32'(busA.cycle_cnt), 32'd0);
        repeat (20) @(posedge clk);
        #1 checkOutput("perf_saturate", 32'(busA.cycle_cnt), 32'hF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
